// File: rtl/word_packer.sv
// Packs PACK_RATIO narrow words into one wide beat, lane 0 least significant.
// Optional idle flush of partial beats is compiled in with WORD_PACKER_TIMEOUT_EN.
module word_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clkIn,
  input  logic                             rstIn,
  input  logic [DATA_WIDTH-1:0]            wrDataIn,
  input  logic                             wrValidIn,
  input  logic                             wrLastIn,
  output logic                             wrReadyOut,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] rdDataOut,
  output logic [PACK_RATIO-1:0]            rdKeepOut,
  output logic                             rdLastOut,
  output logic                             rdValidOut,
  input  logic                             rdReadyIn
);

  localparam int CNT_W  = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam int BEAT_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_RATIO - 1);

  if (PACK_RATIO < 2 || PACK_RATIO > 16) begin : g_bad_ratio
    $error("word_packer: PACK_RATIO out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("word_packer: TIMEOUT_CYCLES out of range");
  end

  logic [BEAT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_W-1:0]     data_q, data_d;
  logic [PACK_RATIO-1:0] keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  logic [BEAT_W-1:0]     merged;
  logic [PACK_RATIO-1:0] keep_full;
  logic                  out_free;
  logic                  accept;
  logic                  complete;

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready. Input ready depends only on reset and the output stage,
  // so the stage can reload in the same edge it hands a beat downstream.
  assign out_free   = !valid_q || rdReadyIn;
  assign wrReadyOut = !rstIn && out_free;
  assign accept     = wrValidIn && wrReadyOut;
  assign complete   = accept && ((cnt_q == CNT_LAST) || wrLastIn);

  // Lanes above cnt are always zero in acc_q, so partial beats zero-fill.
  always_comb begin
    merged = acc_q;
    merged[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = wrDataIn;
    for (int i = 0; i < PACK_RATIO; i++) begin
      keep_full[i] = (i <= int'(cnt_q));
    end
  end

`ifdef WORD_PACKER_TIMEOUT_EN
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT_CYCLES);

  logic [15:0]           idle_q, idle_d;
  logic                  flush;
  logic [PACK_RATIO-1:0] keep_part;

  assign flush = (cnt_q != '0) && !accept && (idle_q >= IDLE_MAX) && out_free;

  always_comb begin
    for (int i = 0; i < PACK_RATIO; i++) begin
      keep_part[i] = (i < int'(cnt_q));
    end
    idle_d = idle_q;
    if (accept || flush || (cnt_q == '0)) begin
      idle_d = '0;
    end else if (idle_q < IDLE_MAX) begin
      idle_d = idle_q + 16'd1;
    end
  end
`endif

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && rdReadyIn) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      data_d  = merged;
      keep_d  = keep_full;
      last_d  = wrLastIn;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      acc_d = merged;
      cnt_d = cnt_q + 1'b1;
    end
`ifdef WORD_PACKER_TIMEOUT_EN
    // A flush only fires with no accepted word, so it never races a completion.
    if (flush) begin
      data_d  = acc_q;
      keep_d  = keep_part;
      last_d  = 1'b0;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef WORD_PACKER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef WORD_PACKER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign rdDataOut  = data_q;
  assign rdKeepOut  = keep_q;
  assign rdLastOut  = last_q;
  assign rdValidOut = valid_q;

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer with default parameters; beats are checked
// against an expected queue of {last, keep, data} entries.
module tb_word_packer;

  localparam int DW = 32;
  localparam int PR = 4;
  localparam int BW = DW * PR;
  localparam int EW = BW + PR + 1;

  logic          clkIn;
  logic          rstIn;
  logic [DW-1:0] wrDataIn;
  logic          wrValidIn;
  logic          wrLastIn;
  logic          wrReadyOut;
  logic [BW-1:0] rdDataOut;
  logic [PR-1:0] rdKeepOut;
  logic          rdLastOut;
  logic          rdValidOut;
  logic          rdReadyIn;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT_CYCLES(16)) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .wrDataIn   (wrDataIn),
    .wrValidIn  (wrValidIn),
    .wrLastIn   (wrLastIn),
    .wrReadyOut (wrReadyOut),
    .rdDataOut  (rdDataOut),
    .rdKeepOut  (rdKeepOut),
    .rdLastOut  (rdLastOut),
    .rdValidOut (rdValidOut),
    .rdReadyIn  (rdReadyIn)
  );

  // clock / reset
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] beat(input logic [BW-1:0] d, input logic [PR-1:0] k, input logic l);
    return {l, k, d};
  endfunction

  // driver tasks: called at a falling edge, return at the falling edge after acceptance
  task automatic send_word(input logic [DW-1:0] d, input logic l, output int stalls);
    stalls    = 0;
    wrDataIn  = d;
    wrLastIn  = l;
    wrValidIn = 1'b1;
    #1;
    while (!wrReadyOut && stalls < 50) begin
      @(negedge clkIn);
      #1;
      stalls++;
    end
    check_eq("wr_ready", EW'(wrReadyOut), EW'(1));
    @(negedge clkIn);
  endtask

  task automatic end_burst();
    wrValidIn = 1'b0;
    wrLastIn  = 1'b0;
    wrDataIn  = '0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clkIn);
      n++;
    end
    check_eq(tag, EW'(exp_q.size()), EW'(0));
  endtask

  // scoreboard: every output handshake must match the head of exp_q
  always @(negedge clkIn) begin
    #3;
    if (!rstIn && rdValidOut && rdReadyIn) begin
      check_eq("beat_expected", EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0) begin
        check_eq("beat", {rdLastOut, rdKeepOut, rdDataOut}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int st;
    rstIn     = 1'b1;
    wrValidIn = 1'b0;
    wrDataIn  = '0;
    wrLastIn  = 1'b0;
    rdReadyIn = 1'b1;
    repeat (3) @(negedge clkIn);
    #1;
    check_eq("rst_wr_ready", EW'(wrReadyOut), EW'(0));
    check_eq("rst_valid", EW'(rdValidOut), EW'(0));
    check_eq("rst_out", {rdLastOut, rdKeepOut, rdDataOut}, EW'(0));
    rstIn = 1'b0;
    #1;
    check_eq("post_rst_ready", EW'(wrReadyOut), EW'(1));
    @(negedge clkIn);

    // full throughput beat, latency 1
    exp_q.push_back(beat({32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 1'b0));
    send_word(32'h11, 1'b0, st);
    send_word(32'h22, 1'b0, st);
    send_word(32'h33, 1'b0, st);
    send_word(32'h44, 1'b0, st);
    end_burst();
    check_eq("lat_valid", EW'(rdValidOut), EW'(1));
    wait_drain("drain_full");

    // short packet
    exp_q.push_back(beat({32'h0, 32'h0, 32'hA2, 32'hA1}, 4'b0011, 1'b1));
    send_word(32'hA1, 1'b0, st);
    send_word(32'hA2, 1'b1, st);
    end_burst();
    wait_drain("drain_short");

    // single-word packets back to back: reload while handing off
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(beat({96'h0, 32'h71 + 32'(i)}, 4'b0001, 1'b1));
      send_word(32'h71 + 32'(i), 1'b1, st);
      check_eq("b2b_stall", EW'(st), EW'(0));
    end
    end_burst();
    wait_drain("drain_b2b");

    // two beats back to back without a stall
    exp_q.push_back(beat({32'h84, 32'h83, 32'h82, 32'h81}, 4'b1111, 1'b0));
    exp_q.push_back(beat({32'h88, 32'h87, 32'h86, 32'h85}, 4'b1111, 1'b0));
    for (int i = 0; i < 8; i++) begin
      send_word(32'h81 + 32'(i), 1'b0, st);
      check_eq("tput_stall", EW'(st), EW'(0));
    end
    end_burst();
    wait_drain("drain_tput");

    // backpressure
    rdReadyIn = 1'b0;
    exp_q.push_back(beat({32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'b1111, 1'b0));
    send_word(32'hC1, 1'b0, st);
    send_word(32'hC2, 1'b0, st);
    send_word(32'hC3, 1'b0, st);
    send_word(32'hC4, 1'b0, st);
    end_burst();
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_ready", EW'(wrReadyOut), EW'(0));
      check_eq("bp_stable", {rdValidOut, rdKeepOut, rdDataOut},
               {1'b1, 4'b1111, 32'hC4, 32'hC3, 32'hC2, 32'hC1});
      @(negedge clkIn);
    end
    rdReadyIn = 1'b1;
    #1;
    check_eq("bp_release", EW'(wrReadyOut), EW'(1));
    wait_drain("drain_bp");

    // last on the final lane: exactly one full beat
    exp_q.push_back(beat({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 4'b1111, 1'b1));
    send_word(32'hD1, 1'b0, st);
    send_word(32'hD2, 1'b0, st);
    send_word(32'hD3, 1'b0, st);
    send_word(32'hD4, 1'b1, st);
    end_burst();
    wait_drain("drain_last4");
    repeat (3) @(negedge clkIn);
    check_eq("no_empty_beat", EW'(rdValidOut), EW'(0));

    // idle partial beat
    send_word(32'h5, 1'b0, st);
    end_burst();
`ifdef WORD_PACKER_TIMEOUT_EN
    exp_q.push_back(beat({96'h0, 32'h5}, 4'b0001, 1'b0));
    wait_drain("drain_flush");
`else
    repeat (100) @(negedge clkIn);
    check_eq("no_flush", EW'(rdValidOut), EW'(0));
    exp_q.push_back(beat({32'h0, 32'h0, 32'h6, 32'h5}, 4'b0011, 1'b1));
    send_word(32'h6, 1'b1, st);
    end_burst();
    wait_drain("drain_hold");
`endif

    // reset mid-packet discards partial words
    send_word(32'hE1, 1'b0, st);
    send_word(32'hE2, 1'b0, st);
    end_burst();
    rstIn = 1'b1;
    #1;
    check_eq("midrst_ready", EW'(wrReadyOut), EW'(0));
    @(negedge clkIn);
    rstIn = 1'b0;
    #1;
    check_eq("midrst_out", {rdValidOut, rdLastOut, rdKeepOut, rdDataOut}, '0);
    @(negedge clkIn);
    exp_q.push_back(beat({32'hF4, 32'hF3, 32'hF2, 32'hF1}, 4'b1111, 1'b0));
    send_word(32'hF1, 1'b0, st);
    send_word(32'hF2, 1'b0, st);
    send_word(32'hF3, 1'b0, st);
    send_word(32'hF4, 1'b0, st);
    end_burst();
    wait_drain("drain_rst");
    repeat (5) @(negedge clkIn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
